// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and kernel-tap helpers for the layer-1
// convolution sequencer.
package cnn_pkg;

  localparam int IMG_W   = 32;
  localparam int K       = 3;
  localparam int OUT_W   = IMG_W - K + 1;
  localparam int N_TAP   = K * K;
  localparam int N_WGT   = 72;
  localparam int N_BIAS  = 8;
  localparam int MAC_LAT = 2;
  localparam int PX_AW   = 10;
  localparam int RES_AW  = 10;
  localparam int W_AW    = 7;
  localparam int B_AW    = 3;
  localparam int RC_W    = 5;
  localparam int T_W     = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CONV  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  // Kernel row offset of tap t (t / 3).
  function automatic logic [1:0] tap_ky(input logic [T_W-1:0] t);
    case (t)
      4'd0, 4'd1, 4'd2: tap_ky = 2'd0;
      4'd3, 4'd4, 4'd5: tap_ky = 2'd1;
      4'd6, 4'd7, 4'd8: tap_ky = 2'd2;
      default:          tap_ky = 2'd0;
    endcase
  endfunction

  // Kernel column offset of tap t (t % 3).
  function automatic logic [1:0] tap_kx(input logic [T_W-1:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: tap_kx = 2'd0;
      4'd1, 4'd4, 4'd7: tap_kx = 2'd1;
      4'd2, 4'd5, 4'd8: tap_kx = 2'd2;
      default:          tap_kx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cnn_conv_sequencer_if.sv
// Buffer-read, MAC-control and result-write bus between the sequencer and
// the convolution datapath.
interface cnn_conv_sequencer_if;
  import cnn_pkg::*;

  logic              w_rd_en;
  logic [W_AW-1:0]   w_rd_addr;
  logic              b_rd_en;
  logic [B_AW-1:0]   b_rd_addr;
  logic              px_rd_en;
  logic [PX_AW-1:0]  px_rd_addr;
  logic              mac_en;
  logic              mac_clear;
  logic              mac_last;
  logic              res_wr_en;
  logic [RES_AW-1:0] res_wr_addr;
  logic              res_wr_ready;

  modport master (
    output w_rd_en, w_rd_addr, b_rd_en, b_rd_addr, px_rd_en, px_rd_addr,
    output mac_en, mac_clear, mac_last, res_wr_en, res_wr_addr,
    input  res_wr_ready
  );

  modport slave (
    input  w_rd_en, w_rd_addr, b_rd_en, b_rd_addr, px_rd_en, px_rd_addr,
    input  mac_en, mac_clear, mac_last, res_wr_en, res_wr_addr,
    output res_wr_ready
  );

endinterface

// File: rtl/cnn_win_addr_gen.sv
// Output-position / kernel-tap walker: tap fastest, then column, then row.
// Produces the pixel address of the current tap, the result address of the
// current position, and first/last/final tap flags.
module cnn_win_addr_gen
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_advance,
  input  logic              i_hold,
  output logic [PX_AW-1:0]  o_px_addr,
  output logic [RES_AW-1:0] o_res_addr,
  output logic              o_first,
  output logic              o_last,
  output logic              o_final
);

  logic [RC_W-1:0] r_row;
  logic [RC_W-1:0] r_col;
  logic [T_W-1:0]  r_tap;
  logic            w_step;
  logic            w_last;
  logic            w_col_end;
  logic            w_row_end;
  logic [RC_W-1:0] w_px_row;
  logic [RC_W-1:0] w_px_col;

  assign w_step    = i_advance && !i_hold;
  assign w_last    = (r_tap == T_W'(N_TAP - 1));
  assign w_col_end = (r_col == RC_W'(OUT_W - 1));
  assign w_row_end = (r_row == RC_W'(OUT_W - 1));

  // Nested row/column/tap counters; the final tap wraps everything to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= 5'd0;
      r_col <= 5'd0;
      r_tap <= 4'd0;
    end else if (w_step) begin
      if (!w_last) begin
        r_tap <= r_tap + 4'd1;
      end else begin
        r_tap <= 4'd0;
        if (!w_col_end) begin
          r_col <= r_col + 5'd1;
        end else begin
          r_col <= 5'd0;
          r_row <= w_row_end ? 5'd0 : r_row + 5'd1;
        end
      end
    end
  end

  // Row and column never exceed 31, so the 32-wide address is a concatenation.
  assign w_px_row   = r_row + RC_W'(tap_ky(r_tap));
  assign w_px_col   = r_col + RC_W'(tap_kx(r_tap));
  assign o_px_addr  = {w_px_row, w_px_col};
  assign o_res_addr = RES_AW'(r_row) * RES_AW'(OUT_W) + RES_AW'(r_col);
  assign o_first    = (r_tap == 4'd0);
  assign o_last     = w_last;
  assign o_final    = w_last && w_col_end && w_row_end;

endmodule

// File: rtl/cnn_conv_sequencer.sv
// Layer-1 3x3 convolution control: weight/bias load, tap issue over the
// 30x30 output grid, MAC enable alignment and result write with backpressure.
// Optional build macro: CNN_SEQ_PERF_EN adds o_perf_stall_cycles.
module cnn_conv_sequencer
  import cnn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_cnn_done,
`ifdef CNN_SEQ_PERF_EN
  output logic [31:0] o_perf_stall_cycles,
`endif
  cnn_conv_sequencer_if.master bus
);

  localparam int PIPE_D = MAC_LAT + 1;

  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [W_AW-1:0]   r_load_cnt;
  logic              w_stall;
  logic              w_issue;
  logic              r_mac_en;
  logic              r_mac_clear;
  logic              r_mac_last;
  logic [PIPE_D-1:0] r_pipe_vld;
  logic [RES_AW-1:0] r_pipe_addr [PIPE_D];
  logic [PX_AW-1:0]  w_px_addr;
  logic [RES_AW-1:0] w_res_addr;
  logic              w_first;
  logic              w_last;
  logic              w_final;

  // A write presented but not accepted freezes the whole sequencer.
  assign w_stall = r_pipe_vld[MAC_LAT] && !bus.res_wr_ready;
  assign w_issue = (r_state == S_CONV) && !w_stall;

  cnn_win_addr_gen u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_advance  (r_state == S_CONV),
    .i_hold     (w_stall),
    .o_px_addr  (w_px_addr),
    .o_res_addr (w_res_addr),
    .o_first    (w_first),
    .o_last     (w_last),
    .o_final    (w_final)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; every wait condition already accounts for stall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD;
        else         w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (!w_stall && (r_load_cnt == W_AW'(N_WGT - 1))) w_state_nxt = S_CONV;
        else                                              w_state_nxt = S_LOAD;
      end
      S_CONV: begin
        if (w_issue && w_final) w_state_nxt = S_DRAIN;
        else                    w_state_nxt = S_CONV;
      end
      S_DRAIN: begin
        if (r_pipe_vld[MAC_LAT] && !w_stall) w_state_nxt = S_DONE;
        else                                 w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Weight/bias load index, one word per LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_cnt <= 7'd0;
    end else if ((r_state == S_LOAD) && !w_stall) begin
      r_load_cnt <= (r_load_cnt == W_AW'(N_WGT - 1)) ? 7'd0 : r_load_cnt + 7'd1;
    end
  end

  // MAC-enable stage and result-address pipe, both frozen during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mac_en    <= 1'b0;
      r_mac_clear <= 1'b0;
      r_mac_last  <= 1'b0;
      r_pipe_vld  <= '0;
      for (int i = 0; i < PIPE_D; i++) r_pipe_addr[i] <= '0;
    end else if (!w_stall) begin
      r_mac_en       <= w_issue;
      r_mac_clear    <= w_issue && w_first;
      r_mac_last     <= w_issue && w_last;
      r_pipe_vld     <= {r_pipe_vld[PIPE_D-2:0], w_issue && w_last};
      r_pipe_addr[0] <= w_res_addr;
      for (int i = 1; i < PIPE_D; i++) r_pipe_addr[i] <= r_pipe_addr[i-1];
    end
  end

`ifdef CNN_SEQ_PERF_EN
  logic [31:0] r_perf_stall;

  // Saturating stall-cycle counter, cleared when a pass is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= 32'd0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_perf_stall <= 32'd0;
    end else if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign o_perf_stall_cycles = r_perf_stall;
`endif

  assign o_busy          = (r_state != S_IDLE);
  assign o_cnn_done      = (r_state == S_DONE);
  assign bus.w_rd_en     = (r_state == S_LOAD);
  assign bus.w_rd_addr   = r_load_cnt;
  assign bus.b_rd_en     = (r_state == S_LOAD) && (r_load_cnt < W_AW'(N_BIAS));
  assign bus.b_rd_addr   = r_load_cnt[B_AW-1:0];
  assign bus.px_rd_en    = (r_state == S_CONV);
  assign bus.px_rd_addr  = w_px_addr;
  assign bus.mac_en      = r_mac_en    && !w_stall;
  assign bus.mac_clear   = r_mac_clear && !w_stall;
  assign bus.mac_last    = r_mac_last  && !w_stall;
  assign bus.res_wr_en   = r_pipe_vld[MAC_LAT];
  assign bus.res_wr_addr = r_pipe_addr[MAC_LAT];

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Scoreboard bench for cnn_conv_sequencer: expected read/write address
// streams and done latency are queued at start; a monitor checks them.
module tb_cnn_conv_sequencer;
  import cnn_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic o_busy;
  logic o_cnn_done;
`ifdef CNN_SEQ_PERF_EN
  logic [31:0] perf;
`endif

  cnn_conv_sequencer_if bus();

  cnn_conv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_cnn_done (o_cnn_done),
`ifdef CNN_SEQ_PERF_EN
    .o_perf_stall_cycles (perf),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_vec = 0;
  int n_err = 0;
  int q_w[$], q_b[$], q_px[$], q_res[$], q_done[$], q_last[$];
  int start_edge = 0;
  int done_cnt = 0;
  int res_cnt = 0;
  int last_px = -1;
  int hold_cnt = 0;
  int stall_seen = 0;
  int stall_addr = -1;
  int stall_left = 0;
  int ns_cnt = 0;
  int tap_exp = 0;
  logic stall;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic pop_check(input string name, inout int q[$], input longint act);
    if (q.size() == 0) check({name, "_unexpected"}, act, -1);
    else               check(name, act, q.pop_front());
  endtask

  function automatic longint all_outputs();
    return {o_busy, o_cnn_done, bus.w_rd_en, bus.w_rd_addr, bus.b_rd_en, bus.b_rd_addr,
            bus.px_rd_en, bus.px_rd_addr, bus.mac_en, bus.mac_clear, bus.mac_last,
            bus.res_wr_en, bus.res_wr_addr};
  endfunction

  // Result sink: backpressures one chosen write for stall_left cycles.
  initial begin
    bus.res_wr_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.res_wr_en && stall_addr >= 0 && int'(bus.res_wr_addr) == stall_addr && stall_left > 0) begin
        bus.res_wr_ready = 1'b0;
        stall_left--;
      end else begin
        bus.res_wr_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every DUT event against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        q_last.delete();
        tap_exp = 0;
      end else begin
        stall = bus.res_wr_en && !bus.res_wr_ready;
        if (bus.w_rd_en) pop_check("w_rd_addr", q_w, bus.w_rd_addr);
        if (bus.b_rd_en) pop_check("b_rd_addr", q_b, bus.b_rd_addr);
        if (bus.px_rd_en && !stall) begin
          pop_check("px_rd_addr", q_px, bus.px_rd_addr);
          last_px = int'(bus.px_rd_addr);
        end
        if (stall) begin
          stall_seen++;
          check("mac_en_in_stall", bus.mac_en, 0);
        end
        if (bus.mac_en) begin
          check("mac_clear", bus.mac_clear, tap_exp == 0);
          check("mac_last", bus.mac_last, tap_exp == 8);
          if (bus.mac_last) q_last.push_back(ns_cnt);
          tap_exp = (tap_exp + 1) % 9;
        end else begin
          check("mac_flags_idle", {bus.mac_clear, bus.mac_last}, 0);
        end
        if (bus.res_wr_en && stall_addr >= 0 && int'(bus.res_wr_addr) == stall_addr) hold_cnt++;
        if (bus.res_wr_en && bus.res_wr_ready) begin
          res_cnt++;
          pop_check("res_wr_addr", q_res, bus.res_wr_addr);
          if (q_last.size() == 0) check("res_after_last_unexpected", 1, 0);
          else                    check("res_after_last_lat", ns_cnt - q_last.pop_front(), MAC_LAT);
        end
        if (o_cnn_done) begin
          done_cnt++;
          check("busy_at_done", o_busy, 1);
          pop_check("done_latency", q_done, edge_n - start_edge);
        end
        if (!stall) ns_cnt++;
      end
    end
  end

  task automatic clear_queues();
    q_w.delete(); q_b.delete(); q_px.delete(); q_res.delete(); q_done.delete();
  endtask

  task automatic push_pass(input int lat);
    for (int i = 0; i < N_WGT; i++) q_w.push_back(i);
    for (int i = 0; i < N_BIAS; i++) q_b.push_back(i);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 30; c++)
        for (int t = 0; t < 9; t++)
          q_px.push_back((r + t / 3) * 32 + c + t % 3);
    for (int i = 0; i < 900; i++) q_res.push_back(i);
    q_done.push_back(lat);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    start_edge = edge_n + 1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_pass(input int st_addr, input int st_len, input int lat, input int restart_at);
    int done0;
    push_pass(lat);
    stall_addr = st_addr;
    stall_left = st_len;
    hold_cnt = 0;
    stall_seen = 0;
    res_cnt = 0;
    last_px = -1;
    done0 = done_cnt;
    pulse_start();
    for (int i = 0; i < 9000 && done_cnt == done0; i++) begin
      @(negedge clk);
      i_start = (i == restart_at);
    end
    i_start = 1'b0;
    repeat (12) @(negedge clk);
    check("done_pulses", done_cnt - done0, 1);
    check("res_writes", res_cnt, 900);
    check("px_left", q_px.size(), 0);
    check("res_left", q_res.size(), 0);
    check("w_left", q_w.size(), 0);
    check("b_left", q_b.size(), 0);
    check("last_px_addr", last_px, 1023);
    check("busy_after", o_busy, 0);
    clear_queues();
    stall_addr = -1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 check("reset_outputs", all_outputs(), 0);
    @(negedge clk);
    rst = 1'b0;

    // Clean pass: load order, tap order, 900 writes, done at 8175.
    run_pass(-1, 0, 8175, -1);
`ifdef CNN_SEQ_PERF_EN
    check("perf_clean", perf, 0);
`endif

    // Backpressure at write 100 for 5 cycles, plus a stray start at cycle 500.
    run_pass(100, 5, 8180, 500);
    check("hold_cycles", hold_cnt, 6);
    check("stall_cycles", stall_seen, 5);
`ifdef CNN_SEQ_PERF_EN
    check("perf_stall", perf, 5);
`endif

    // Abort mid-CONV with reset, then a clean pass again.
    begin
      int done0;
      done0 = done_cnt;
      push_pass(8175);
      pulse_start();
      repeat (3000) @(negedge clk);
      rst = 1'b1;
      clear_queues();
      @(negedge clk);
      rst = 1'b0;
      #2 check("abort_outputs", all_outputs(), 0);
      repeat (20) @(negedge clk);
      check("abort_no_done", done_cnt - done0, 0);
    end
    run_pass(-1, 0, 8175, -1);
`ifdef CNN_SEQ_PERF_EN
    check("perf_after_abort", perf, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
